// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divider sequencer for RV32M DIV/DIVU/REM/REMU.
// Optional build macro DIV_SPECIAL_BYPASS_EN: divide-by-zero and signed overflow finish in one cycle.
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_req,
    input  logic [1:0]       div_opcode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             div_stall,
    output logic             div_done,
    output logic [WIDTH-1:0] div_result
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             selRem_q;
    logic             negQuo_q;
    logic             negRem_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] result_q;

    logic             isSigned;
    logic             startNegQuo;
    logic             startNegRem;
    logic [WIDTH-1:0] absDividend;
    logic [WIDTH-1:0] absDivisor;
    logic [WIDTH:0]   remShift;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] result_d;

    // Sign correction of the unsigned quotient/remainder and final selection.
    function automatic logic [WIDTH-1:0] correct(input logic [WIDTH-1:0] quo,
                                                 input logic [WIDTH-1:0] rem,
                                                 input logic             selRem,
                                                 input logic             negQuo,
                                                 input logic             negRem);
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        q = negQuo ? (~quo + 1'b1) : quo;
        r = negRem ? (~rem + 1'b1) : rem;
        return selRem ? r : q;
    endfunction

    always_comb begin
        isSigned    = ~div_opcode[0];
        absDividend = (isSigned && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
        absDivisor  = (isSigned && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;
        startNegQuo = isSigned && (dividend[WIDTH-1] ^ divisor[WIDTH-1]) && (divisor != '0);
        startNegRem = isSigned && dividend[WIDTH-1];
        remShift    = {rem_q, quo_q[WIDTH-1]};
        diff        = remShift - {1'b0, dvs_q};
        rem_d       = diff[WIDTH] ? remShift[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_d       = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        result_d    = correct(quo_d, rem_d, selRem_q, negQuo_q, negRem_q);
    end

`ifdef DIV_SPECIAL_BYPASS_EN
    logic             divByZero;
    logic             isSpecial;
    logic [WIDTH-1:0] bypassResult;

    // Raw unsigned results the iteration would produce, fed through the same correction.
    always_comb begin
        divByZero    = (divisor == '0);
        isSpecial    = divByZero ||
                       (isSigned && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == {WIDTH{1'b1}}));
        bypassResult = correct(divByZero ? {WIDTH{1'b1}} : absDividend,
                               divByZero ? absDividend : {WIDTH{1'b0}},
                               div_opcode[1], startNegQuo, startNegRem);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            selRem_q <= 1'b0;
            negQuo_q <= 1'b0;
            negRem_q <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (div_req && !flush) begin
                        selRem_q <= div_opcode[1];
                        negQuo_q <= startNegQuo;
                        negRem_q <= startNegRem;
                        quo_q    <= absDividend;
                        dvs_q    <= absDivisor;
                        rem_q    <= '0;
                        cnt_q    <= CW'(WIDTH - 1);
`ifdef DIV_SPECIAL_BYPASS_EN
                        if (isSpecial) begin
                            result_q <= bypassResult;
                            state_q  <= DONE;
                        end else begin
                            state_q  <= CALC;
                        end
`else
                        state_q  <= CALC;
`endif
                    end
                end
                CALC: begin
                    if (flush || !div_req) begin
                        state_q <= IDLE;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == '0) begin
                            result_q <= result_d;
                            state_q  <= DONE;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign div_done   = (state_q == DONE) && !flush;
    assign div_stall  = div_req && !div_done && !flush;
    assign div_result = result_q;

    // A divide must stay requested until it completes; dropping it is handled like a flush.
    assert property (@(posedge clk) disable iff (rst) (state_q == CALC) |-> (div_req || flush));

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer (WIDTH=32), aware of DIV_SPECIAL_BYPASS_EN latency.
module tb_div_sequencer;

    logic        clk;
    logic        rst;
    logic        div_req;
    logic [1:0]  div_opcode;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        div_stall;
    logic        div_done;
    logic [31:0] div_result;

    int checkCount = 0;
    int errorCount = 0;

`ifdef DIV_SPECIAL_BYPASS_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = 33;
`endif

    div_sequencer #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_req    (div_req),
        .div_opcode (div_opcode),
        .dividend   (dividend),
        .divisor    (divisor),
        .flush      (flush),
        .div_stall  (div_stall),
        .div_done   (div_done),
        .div_result (div_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one divide at the current negedge, scrambles the operands after they are
    // sampled, and returns at the negedge of the IDLE cycle following div_done.
    task automatic applyStimulus(input logic [1:0] opc, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output int lat, output int stallCycles);
        div_opcode  = opc;
        dividend    = a;
        divisor     = b;
        div_req     = 1'b1;
        res         = '0;
        lat         = -1;
        stallCycles = 0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (div_stall) stallCycles++;
            if (div_done) begin
                lat = c;
                res = div_result;
                break;
            end
            @(negedge clk);
            dividend = ~a;
            divisor  = b + 32'd3;
        end
        @(negedge clk);
    endtask

    task automatic idleCycle();
        div_req = 1'b0;
        flush   = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        div_req    = 1'b1;
        div_opcode = 2'b00;
        dividend   = 32'd100;
        divisor    = 32'd7;
        flush      = 1'b0;
        @(negedge clk);
        #1;
        checkCount++;
        if (div_done !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL reset_done got %b want 0", div_done);
        end
        checkCount++;
        if (div_result !== 32'h0) begin
            errorCount++;
            $display("[TB] FAIL reset_result got %h want 00000000", div_result);
        end
        div_req = 1'b0;
        #1;
        checkCount++;
        if (div_stall !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL reset_stall got %b want 0", div_stall);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [31:0] res;
        int lat;
        int st;
        applyStimulus(2'b00, 32'd100, 32'd7, res, lat, st);
        idleCycle();
        checkCount++;
        if (res !== 32'd14) begin
            errorCount++;
            $display("[TB] FAIL div_100_7 got %h want %h", res, 32'd14);
        end
        checkCount++;
        if (lat !== 33) begin
            errorCount++;
            $display("[TB] FAIL div_100_7_latency got %0d want 33", lat);
        end
        checkCount++;
        if (st !== 33) begin
            errorCount++;
            $display("[TB] FAIL div_100_7_stall_cycles got %0d want 33", st);
        end
        applyStimulus(2'b10, 32'd100, 32'd7, res, lat, st);
        idleCycle();
        checkCount++;
        if (res !== 32'd2) begin
            errorCount++;
            $display("[TB] FAIL rem_100_7 got %h want %h", res, 32'd2);
        end
        checkCount++;
        if (lat !== 33) begin
            errorCount++;
            $display("[TB] FAIL rem_100_7_latency got %0d want 33", lat);
        end
    endtask

    task automatic test_signed();
        logic [1:0]  opcV [7];
        logic [31:0] aV   [7];
        logic [31:0] bV   [7];
        logic [31:0] expV [7];
        logic [31:0] res;
        int lat;
        int st;
        opcV = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b00};
        aV   = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd7, 32'hFFFFFFF9, 32'hFFFFFF9C};
        bV   = '{32'd2, 32'd2, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd2, 32'hFFFFFFF9};
        expV = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h7FFFFFFC, 32'hFFFFFFFD, 32'd1, 32'd1, 32'd14};
        for (int i = 0; i < 7; i++) begin
            applyStimulus(opcV[i], aV[i], bV[i], res, lat, st);
            idleCycle();
            checkCount++;
            if (res !== expV[i]) begin
                errorCount++;
                $display("[TB] FAIL signed[%0d] got %h want %h", i, res, expV[i]);
            end
            checkCount++;
            if (lat !== 33) begin
                errorCount++;
                $display("[TB] FAIL signed_latency[%0d] got %0d want 33", i, lat);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [1:0]  opcV [5];
        logic [31:0] aV   [5];
        logic [31:0] expV [5];
        logic [31:0] res;
        int lat;
        int st;
        opcV = '{2'b00, 2'b11, 2'b00, 2'b10, 2'b01};
        aV   = '{32'd5, 32'd5, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'd5};
        expV = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'hFFFFFFFF};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(opcV[i], aV[i], 32'd0, res, lat, st);
            idleCycle();
            checkCount++;
            if (res !== expV[i]) begin
                errorCount++;
                $display("[TB] FAIL divzero[%0d] got %h want %h", i, res, expV[i]);
            end
            checkCount++;
            if (lat !== SPECIAL_LAT) begin
                errorCount++;
                $display("[TB] FAIL divzero_latency[%0d] got %0d want %0d", i, lat, SPECIAL_LAT);
            end
        end
    endtask

    task automatic test_overflow();
        logic [1:0]  opcV [4];
        logic [31:0] expV [4];
        int          latV [4];
        logic [31:0] res;
        int lat;
        int st;
        opcV = '{2'b00, 2'b10, 2'b01, 2'b11};
        expV = '{32'h80000000, 32'h0, 32'h0, 32'h80000000};
        latV = '{SPECIAL_LAT, SPECIAL_LAT, 33, 33};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(opcV[i], 32'h80000000, 32'hFFFFFFFF, res, lat, st);
            idleCycle();
            checkCount++;
            if (res !== expV[i]) begin
                errorCount++;
                $display("[TB] FAIL overflow[%0d] got %h want %h", i, res, expV[i]);
            end
            checkCount++;
            if (lat !== latV[i]) begin
                errorCount++;
                $display("[TB] FAIL overflow_latency[%0d] got %0d want %0d", i, lat, latV[i]);
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int lat;
        int st;
        // flush beats a request in IDLE: the real start is one cycle later
        div_opcode = 2'b01;
        dividend   = 32'd1000;
        divisor    = 32'd3;
        div_req    = 1'b1;
        flush      = 1'b1;
        #1;
        checkCount++;
        if (div_stall !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL flush_idle_stall got %b want 0", div_stall);
        end
        @(negedge clk);
        flush = 1'b0;
        applyStimulus(2'b01, 32'd1000, 32'd3, res, lat, st);
        idleCycle();
        checkCount++;
        if (res !== 32'd333 || lat !== 33) begin
            errorCount++;
            $display("[TB] FAIL flush_idle_priority got %h lat %0d want %h lat 33", res, lat, 32'd333);
        end

        div_opcode = 2'b01;
        dividend   = 32'd1000;
        divisor    = 32'd3;
        div_req    = 1'b1;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        checkCount++;
        if (div_stall !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL flush_calc_stall got %b want 0", div_stall);
        end
        checkCount++;
        if (div_done !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL flush_calc_done got %b want 0", div_done);
        end
        @(negedge clk);
        flush = 1'b0;
        applyStimulus(2'b01, 32'd9, 32'd3, res, lat, st);
        idleCycle();
        checkCount++;
        if (res !== 32'd3) begin
            errorCount++;
            $display("[TB] FAIL flush_then_divu got %h want %h", res, 32'd3);
        end
        checkCount++;
        if (lat !== 33) begin
            errorCount++;
            $display("[TB] FAIL flush_then_divu_latency got %0d want 33", lat);
        end

        div_opcode = 2'b00;
        dividend   = 32'd100;
        divisor    = 32'd7;
        div_req    = 1'b1;
        repeat (33) @(negedge clk);
        flush = 1'b1;
        #1;
        checkCount++;
        if (div_done !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL flush_done_suppress got %b want 0", div_done);
        end
        @(negedge clk);
        flush   = 1'b0;
        div_req = 1'b0;
        #1;
        checkCount++;
        if (div_done !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL flush_done_after got %b want 0", div_done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int lat;
        int st;
        int doneSeen;
        div_opcode = 2'b00;
        dividend   = 32'd100;
        divisor    = 32'd7;
        div_req    = 1'b1;
        repeat (6) @(negedge clk);
        #2;
        rst     = 1'b1;
        div_req = 1'b0;
        #1;
        checkCount++;
        if (div_result !== 32'h0) begin
            errorCount++;
            $display("[TB] FAIL async_reset_result got %h want 00000000", div_result);
        end
        checkCount++;
        if (div_done !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL async_reset_done got %b want 0", div_done);
        end
        @(negedge clk);
        rst      = 1'b0;
        doneSeen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (div_done) doneSeen++;
        end
        checkCount++;
        if (doneSeen !== 0) begin
            errorCount++;
            $display("[TB] FAIL reset_abandons_op got %0d done pulses want 0", doneSeen);
        end
        applyStimulus(2'b01, 32'd9, 32'd3, res, lat, st);
        idleCycle();
        checkCount++;
        if (res !== 32'd3 || lat !== 33) begin
            errorCount++;
            $display("[TB] FAIL after_reset_divu got %h lat %0d want %h lat 33", res, lat, 32'd3);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] r3;
        int l1;
        int l2;
        int l3;
        int st;
        applyStimulus(2'b00, 32'd100, 32'd7, r1, l1, st);
        applyStimulus(2'b10, 32'hFFFFFF9C, 32'd7, r2, l2, st);
        applyStimulus(2'b01, 32'd9, 32'd3, r3, l3, st);
        idleCycle();
        checkCount++;
        if (r1 !== 32'd14 || l1 !== 33) begin
            errorCount++;
            $display("[TB] FAIL b2b_first got %h lat %0d want %h lat 33", r1, l1, 32'd14);
        end
        checkCount++;
        if (r2 !== 32'hFFFFFFFE || l2 !== 33) begin
            errorCount++;
            $display("[TB] FAIL b2b_second got %h lat %0d want fffffffe lat 33", r2, l2);
        end
        checkCount++;
        if (r3 !== 32'd3 || l3 !== 33) begin
            errorCount++;
            $display("[TB] FAIL b2b_third got %h lat %0d want %h lat 33", r3, l3, 32'd3);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_div_zero();
        test_overflow();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
